// File: rtl/spi_sensor_pkg.sv
// Shared types and helpers for the SPI sensor sequencer.
// Holds the FSM state enum, the read flag and the read-command builder.
package spi_sensor_pkg;

    typedef enum logic [2:0] {
        PWR_DLY,
        INIT_WR,
        INIT_WT,
        POLL,
        RD_WR,
        RD_WT,
        FRAME
    } state_t;

    localparam logic RD_FLAG = 1'b1;

    // Read command: {RD_FLAG, address, 8'h00}; the address wraps mod 128.
    function automatic logic [15:0] rd_cmd(
        input logic [6:0] base,
        input logic [4:0] k
    );
        logic [6:0] addr;
        addr = base + {2'b00, k};
        return {RD_FLAG, addr, 8'h00};
    endfunction

endpackage

// File: rtl/int_sync_det.sv
// Two-flop synchroniser for the asynchronous sensor INT line plus trigger.
// Ports: clk, rst_n, int_i (async INT), trig_o (level or rising-edge trigger).
module int_sync_det #(
    parameter int INT_EDGE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic int_i,
    output logic trig_o
);

    // [1:0] form the synchroniser, [2] is the delayed copy for edge detect.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], int_i};
        end
    end

    always_comb begin
        trig_o = (INT_EDGE != 0) ? (sync_q[1] & ~sync_q[2]) : sync_q[1];
    end

endmodule

// File: rtl/spi_sensor_seq.sv
// SPI sensor sequencer: power-up delay, init-table writes, then INT-driven
// burst reads assembling NUM_CH little-endian 16-bit channels.
// Ports: clk, rst_n, INT, reinit, init_tbl, rd_base in; wrt/cmd to the SPI
// master, done/rd_data from it; ch_data, vld, init_done, tmo_err, busy out.
module spi_sensor_seq
    import spi_sensor_pkg::*;
#(
    parameter int NUM_INIT = 4,
    parameter int NUM_CH   = 5,
    parameter int DLY_W    = 16,
    parameter int TMO_W    = 20,
    parameter int INT_EDGE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     INT,
    input  logic                     reinit,
    input  logic [16*NUM_INIT-1:0]   init_tbl,
    input  logic [6:0]               rd_base,
    output logic                     wrt,
    output logic [15:0]              cmd,
    input  logic                     done,
    input  logic [15:0]              rd_data,
    output logic [16*NUM_CH-1:0]     ch_data,
    output logic                     vld,
    output logic                     init_done,
    output logic                     tmo_err,
    output logic                     busy
);

    localparam logic [2:0] IDX_LAST = 3'(NUM_INIT - 1);
    localparam logic [4:0] K_LAST   = 5'(2 * NUM_CH - 1);

    state_t               state_q;
    logic [DLY_W-1:0]     dly_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [2:0]           idx_q;
    logic [4:0]           k_q;
    logic                 pend_q;
    logic [16*NUM_CH-1:0] shadow_q;
    logic [16*NUM_CH-1:0] shadow_d;
    logic [16*NUM_CH-1:0] ch_q;
    logic                 wrt_q;
    logic [15:0]          cmd_q;
    logic                 vld_q;
    logic                 init_done_q;
    logic                 tmo_err_q;
    logic                 busy_q;
    logic                 trig;
    logic                 in_wt;
    logic                 unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    int_sync_det #(
        .INT_EDGE (INT_EDGE)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .int_i  (INT),
        .trig_o (trig)
    );

    // Byte k lands at shadow[8k+:8]: even k is a low byte, odd k a high byte.
    always_comb begin
        shadow_d = shadow_q;
        shadow_d[8*k_q +: 8] = rd_data[7:0];
    end

    assign in_wt = (state_q == INIT_WT) || (state_q == RD_WT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWR_DLY;
            dly_q       <= '0;
            tmo_q       <= '0;
            idx_q       <= '0;
            k_q         <= '0;
            pend_q      <= 1'b0;
            shadow_q    <= '0;
            ch_q        <= '0;
            wrt_q       <= 1'b0;
            cmd_q       <= '0;
            vld_q       <= 1'b0;
            init_done_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wrt_q <= 1'b0;
            vld_q <= 1'b0;
            if (reinit && !in_wt) begin
                state_q     <= PWR_DLY;
                dly_q       <= '0;
                tmo_q       <= '0;
                idx_q       <= '0;
                pend_q      <= 1'b0;
                init_done_q <= 1'b0;
                tmo_err_q   <= 1'b0;
            end else begin
                // A reinit during a transaction waits for its done.
                if (reinit) begin
                    pend_q <= 1'b1;
                end
                unique case (state_q)
                    PWR_DLY: begin
                        if (dly_q == '1) begin
                            dly_q   <= '0;
                            state_q <= INIT_WR;
                        end else begin
                            dly_q <= dly_q + 1'b1;
                        end
                    end
                    INIT_WR: begin
                        wrt_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cmd_q   <= init_tbl[16*idx_q +: 16];
                        state_q <= INIT_WT;
                    end
                    INIT_WT: begin
                        if (done) begin
                            busy_q <= 1'b0;
                            if (pend_q || reinit) begin
                                state_q     <= PWR_DLY;
                                dly_q       <= '0;
                                tmo_q       <= '0;
                                idx_q       <= '0;
                                pend_q      <= 1'b0;
                                init_done_q <= 1'b0;
                                tmo_err_q   <= 1'b0;
                            end else if (idx_q != IDX_LAST) begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= PWR_DLY;
                            end else begin
                                init_done_q <= 1'b1;
                                state_q     <= POLL;
                            end
                        end
                    end
                    POLL: begin
                        if (trig) begin
                            tmo_q   <= '0;
                            k_q     <= '0;
                            state_q <= RD_WR;
                        end else if (tmo_q == '1) begin
                            tmo_err_q <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    RD_WR: begin
                        wrt_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cmd_q   <= rd_cmd(rd_base, k_q);
                        state_q <= RD_WT;
                    end
                    RD_WT: begin
                        if (done) begin
                            busy_q   <= 1'b0;
                            shadow_q <= shadow_d;
                            if (pend_q || reinit) begin
                                // Partial frame dropped; ch_data kept.
                                state_q     <= PWR_DLY;
                                dly_q       <= '0;
                                tmo_q       <= '0;
                                idx_q       <= '0;
                                pend_q      <= 1'b0;
                                init_done_q <= 1'b0;
                                tmo_err_q   <= 1'b0;
                            end else if (k_q != K_LAST) begin
                                k_q     <= k_q + 1'b1;
                                state_q <= RD_WR;
                            end else begin
                                // Publish with the final byte merged so vld
                                // follows the last done by one cycle.
                                ch_q    <= shadow_d;
                                vld_q   <= 1'b1;
                                state_q <= FRAME;
                            end
                        end
                    end
                    FRAME: begin
                        state_q <= POLL;
                    end
                    default: begin
                        state_q <= PWR_DLY;
                    end
                endcase
            end
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign ch_data   = ch_q;
    assign vld       = vld_q;
    assign init_done = init_done_q;
    assign tmo_err   = tmo_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_sensor_seq.sv
// Scoreboard bench for spi_sensor_seq: level-mode DUT checked by queues,
// plus an edge-mode DUT for the single-trigger behaviour.
module tb_spi_sensor_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic int_l = 1'b0;
    logic int_e = 1'b0;
    logic reinit = 1'b0;
    logic [63:0] init_tbl = {16'h1460, 16'h1162, 16'h1062, 16'h0D02};
    logic [6:0] rd_base = 7'h22;

    logic        wrt_l, done_l, vld_l, idn_l, tmo_l, busy_l;
    logic [15:0] cmd_l, rdd_l;
    logic [79:0] ch_l;
    logic        wrt_e, done_e, vld_e, idn_e, tmo_e, busy_e;
    logic [15:0] cmd_e, rdd_e;
    logic [79:0] ch_e;

    localparam logic [79:0] FRM = 80'h2B2A_2928_2726_2524_2322;

    always #5 clk = ~clk;

    spi_sensor_seq #(
        .NUM_INIT(4), .NUM_CH(5), .DLY_W(4), .TMO_W(6), .INT_EDGE(0)
    ) dut_l (
        .clk(clk), .rst_n(rst_n), .INT(int_l), .reinit(reinit),
        .init_tbl(init_tbl), .rd_base(rd_base), .wrt(wrt_l),
        .cmd(cmd_l), .done(done_l), .rd_data(rdd_l), .ch_data(ch_l),
        .vld(vld_l), .init_done(idn_l), .tmo_err(tmo_l), .busy(busy_l)
    );

    spi_sensor_seq #(
        .NUM_INIT(4), .NUM_CH(5), .DLY_W(4), .TMO_W(6), .INT_EDGE(1)
    ) dut_e (
        .clk(clk), .rst_n(rst_n), .INT(int_e), .reinit(reinit),
        .init_tbl(init_tbl), .rd_base(rd_base), .wrt(wrt_e),
        .cmd(cmd_e), .done(done_e), .rd_data(rdd_e), .ch_data(ch_e),
        .vld(vld_e), .init_done(idn_e), .tmo_err(tmo_e), .busy(busy_e)
    );

    // SPI master models: done three cycles after wrt, byte = address.
    logic [1:0]  lat_l, lat_e;
    logic [15:0] cap_l, cap_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_l <= 0; done_l <= 0; rdd_l <= 0; cap_l <= 0;
        end else begin
            done_l <= 1'b0;
            if (wrt_l) begin
                cap_l <= cmd_l;
                lat_l <= 2'd3;
            end else if (lat_l != 0) begin
                lat_l <= lat_l - 1'b1;
                if (lat_l == 2'd1) begin
                    done_l <= 1'b1;
                    rdd_l  <= {9'h0, cap_l[14:8]};
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_e <= 0; done_e <= 0; rdd_e <= 0; cap_e <= 0;
        end else begin
            done_e <= 1'b0;
            if (wrt_e) begin
                cap_e <= cmd_e;
                lat_e <= 2'd3;
            end else if (lat_e != 0) begin
                lat_e <= lat_e - 1'b1;
                if (lat_e == 2'd1) begin
                    done_e <= 1'b1;
                    rdd_e  <= {9'h0, cap_e[14:8]};
                end
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_done = -100;
    int n_vld_l = 0;
    int n_vld_e = 0;
    logic vld_prev = 1'b0;
    logic idn_prev = 1'b0;
    logic [15:0] exp_cmd[$];
    logic [79:0] exp_frm[$];

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic fail(input string nm, input logic [79:0] act);
        n_chk++;
        $display("FAIL %s: got %h want none", nm, act);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard whenever the level DUT presents output.
    always @(negedge clk) begin
        if (!rst_n) begin
            vld_prev = 1'b0;
            idn_prev = 1'b0;
        end else begin
            if (done_l) last_done = cyc;
            if (wrt_l) begin
                if (!cmd_l[15])
                    chk("init gap", 80'((cyc - last_done) >= 15), 80'(1));
                if (exp_cmd.size() == 0) fail("unexpected cmd", 80'(cmd_l));
                else chk("cmd", 80'(cmd_l), 80'(exp_cmd.pop_front()));
            end
            if (vld_prev) chk("vld single pulse", 80'(vld_l), 80'(0));
            if (vld_l) begin
                n_vld_l++;
                chk("vld latency", 80'(cyc - last_done), 80'(1));
                if (exp_frm.size() == 0) fail("unexpected frame", ch_l);
                else chk("frame", ch_l, exp_frm.pop_front());
            end
            if (idn_l && !idn_prev)
                chk("init_done latency", 80'(cyc - last_done), 80'(1));
            vld_prev = vld_l;
            idn_prev = idn_l;
        end
    end

    always @(negedge clk) if (rst_n && vld_e) n_vld_e++;

    task automatic push_init();
        exp_cmd.push_back(16'h0D02);
        exp_cmd.push_back(16'h1062);
        exp_cmd.push_back(16'h1162);
        exp_cmd.push_back(16'h1460);
    endtask

    task automatic push_reads(input int n);
        logic [15:0] tbl [10] = '{16'hA200, 16'hA300, 16'hA400, 16'hA500,
            16'hA600, 16'hA700, 16'hA800, 16'hA900, 16'hAA00, 16'hAB00};
        for (int i = 0; i < n; i++) exp_cmd.push_back(tbl[i]);
    endtask

    task automatic wait_init(input bit e, input string nm);
        int i = 0;
        while (i < 2000 && !(e ? idn_e : idn_l)) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 80'(e ? idn_e : idn_l), 80'(1));
    endtask

    task automatic wait_vld(input string nm);
        int i = 0;
        @(negedge clk);
        while (i < 2000 && !vld_l) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 80'(vld_l), 80'(1));
    endtask

    task automatic wait_cmd(input logic [15:0] c, input string nm);
        int i = 0;
        while (i < 2000 && !(wrt_l && cmd_l == c)) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 80'(wrt_l && cmd_l == c), 80'(1));
    endtask

    task automatic pulse_int();
        int_l = 1'b1;
        @(negedge clk);
        int_l = 1'b0;
    endtask

    initial begin
        int base;
        int i;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst wrt", 80'(wrt_l), 80'(0));
        chk("rst vld", 80'(vld_l), 80'(0));
        chk("rst init_done", 80'(idn_l), 80'(0));
        chk("rst tmo_err", 80'(tmo_l), 80'(0));
        chk("rst busy", 80'(busy_l), 80'(0));
        chk("rst ch_data", ch_l, 80'(0));
        push_init();
        rst_n = 1'b1;
        wait_init(0, "init_done level");
        wait_init(1, "init_done edge");
        chk("init cmds issued", 80'(exp_cmd.size()), 80'(0));
        chk("tmo_err early", 80'(tmo_l), 80'(0));
        repeat (70) @(negedge clk);
        chk("tmo_err set", 80'(tmo_l), 80'(1));

        push_reads(10);
        exp_frm.push_back(FRM);
        pulse_int();
        wait_vld("frame vld");
        repeat (2) @(negedge clk);
        chk("tmo_err sticky", 80'(tmo_l), 80'(1));
        chk("ch0", 80'(ch_l[15:0]), 80'(16'h2322));
        chk("ch4", 80'(ch_l[79:64]), 80'(16'h2B2A));

        push_init();
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        chk("reinit tmo_err", 80'(tmo_l), 80'(0));
        chk("reinit init_done", 80'(idn_l), 80'(0));
        chk("reinit keeps ch", ch_l, FRM);
        wait_init(0, "replay level");
        wait_init(1, "replay edge");

        base = n_vld_l;
        push_reads(10);
        push_reads(10);
        exp_frm.push_back(FRM);
        exp_frm.push_back(FRM);
        int_l = 1'b1;
        wait_vld("b2b vld1");
        int_l = 1'b0;
        wait_vld("b2b vld2");
        repeat (100) @(negedge clk);
        chk("level frames", 80'(n_vld_l - base), 80'(2));

        base = n_vld_e;
        int_e = 1'b1;
        repeat (200) @(negedge clk);
        int_e = 1'b0;
        repeat (5) @(negedge clk);
        chk("edge frames", 80'(n_vld_e - base), 80'(1));
        chk("edge ch0", 80'(ch_e[15:0]), 80'(16'h2322));

        rd_base = 7'h7E;
        exp_cmd.push_back(16'hFE00);
        exp_cmd.push_back(16'hFF00);
        exp_cmd.push_back(16'h8000);
        exp_cmd.push_back(16'h8100);
        push_init();
        pulse_int();
        wait_cmd(16'h8100, "k3 read");
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        chk("pending busy", 80'(busy_l), 80'(1));
        i = 0;
        while (i < 50 && busy_l) begin
            @(negedge clk);
            i++;
        end
        chk("pending done", 80'(busy_l), 80'(0));
        chk("pending init_done", 80'(idn_l), 80'(0));
        wait_init(0, "replay after pend");
        chk("partial ch kept", ch_l, FRM);
        rd_base = 7'h22;

        push_reads(3);
        pulse_int();
        wait_cmd(16'hA400, "pre-reset read");
        #2 rst_n = 1'b0;
        #1;
        chk("async wrt", 80'(wrt_l), 80'(0));
        chk("async vld", 80'(vld_l), 80'(0));
        chk("async init_done", 80'(idn_l), 80'(0));
        chk("async busy", 80'(busy_l), 80'(0));
        chk("async ch_data", ch_l, 80'(0));
        chk("queue before rst", 80'(exp_cmd.size()), 80'(0));
        repeat (3) @(negedge clk);
        push_init();
        rst_n = 1'b1;
        wait_init(0, "restart level");
        wait_init(1, "restart edge");
        chk("cmd queue empty", 80'(exp_cmd.size()), 80'(0));
        chk("frame queue empty", 80'(exp_frm.size()), 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
